fetch_flush_queue: RTL

// - Instruction queue between IF and ID; the consumer of the jump Flush signal.
// - Buffers fetched instructions and issues them to decode.
// - Detects issued jumps and drives the Jump pulse to the jump-flush FSM.
// - While Flush is high, discards wrong-path entries and issues bubbles; the single delay-slot instruction always survives.

---
 rtl/fetch_flush_queue_pkg.sv | 22 ++
 rtl/fetch_flush_queue_jump_classify.sv | 16 +
 rtl/fetch_flush_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_flush_queue_pkg.sv
// Shared constants and types for the fetch/flush instruction queue.
// Optional build macro: FETCH_FLUSH_STATS_EN (squash/bubble counters; DEBUG_PRINT adds a message).
package fetch_flush_queue_pkg;

   // MIPS opcode / funct fields that identify control transfers
   localparam logic [5:0]  OP_RTYPE = 6'h00;
   localparam logic [5:0]  OP_J     = 6'h02;
   localparam logic [5:0]  OP_JAL   = 6'h03;
   localparam logic [5:0]  FN_JR    = 6'h08;
   localparam logic [5:0]  FN_JALR  = 6'h09;

   // Encoding of the bubble placed on the decode side
   localparam logic [31:0] NOP      = 32'h0000_0000;

   // What the decode registers do on the coming edge
   typedef enum logic [1:0] {
      IssueHold,
      IssueBubble,
      IssueHead
   } issue_e;

endpackage

// File: rtl/fetch_flush_queue_jump_classify.sv
// Combinational classifier: flags J, JAL, JR and JALR from the opcode and funct fields.
module fetch_flush_queue_jump_classify
   import fetch_flush_queue_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic       is_jump_o
);

   // Direct jumps by opcode, register jumps by R-type funct
   always_comb begin
      is_jump_o = (op_i == OP_J) || (op_i == OP_JAL) ||
                  ((op_i == OP_RTYPE) && ((funct_i == FN_JR) || (funct_i == FN_JALR)));
   end

endmodule

// File: rtl/fetch_flush_queue.sv
// Instruction queue between fetch and decode. Issues one entry per unstalled cycle, raises a
// one-cycle Jump pulse when a jump issues, and on Flush drops wrong-path entries while letting
// the pending delay-slot instruction through.
// Optional build macro: FETCH_FLUSH_STATS_EN adds internal SquashCount/BubbleCount counters;
// with DEBUG_PRINT also defined each discard prints "Squash on Flush".
module fetch_flush_queue
   import fetch_flush_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] InstrF,
   input  logic [WIDTH-1:0] PCPlus4F,
   input  logic             ValidF,
   output logic             ReadyF,
   input  logic             Stall,
   input  logic             Flush,
   output logic [WIDTH-1:0] InstrD,
   output logic [WIDTH-1:0] PCPlus4D,
   output logic             ValidD,
   output logic             Jump
);

   localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);
   localparam logic [PtrW:0] OneCnt   = (PtrW + 1)'(1);

   // Queue storage
   logic [WIDTH-1:0] instr_mem_q [DEPTH];
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];

   // Pointers and occupancy
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]    count_q, count_d;

   // Decode-side registers
   logic [WIDTH-1:0] issue_instr_q, issue_instr_d;
   logic [WIDTH-1:0] issue_pc_q, issue_pc_d;
   logic             issue_valid_q, issue_valid_d;
   logic             jump_q, jump_d;
   logic             ds_pending_q, ds_pending_d;

   logic             empty, full, push, pop, keep_ds, head_is_jump;
   logic [WIDTH-1:0] head_instr, head_pc;
   issue_e           issue;

   assign empty      = (count_q == '0);
   assign full       = (count_q == DepthCnt);
   assign head_instr = instr_mem_q[rd_ptr_q];
   assign head_pc    = pc_mem_q[rd_ptr_q];

   fetch_flush_queue_jump_classify u_jump_classify (
      .op_i      (head_instr[31:26]),
      .funct_i   (head_instr[5:0]),
      .is_jump_o (head_is_jump)
   );

   // Push handshake and delay-slot survival on Flush
   always_comb begin
      ReadyF  = ~full & ~Flush;
      push    = ValidF & ReadyF;
      keep_ds = Flush & ds_pending_q & ~empty;
   end

   // Choose what decode sees next: hold on stall, head if available and not squashed, else bubble
   always_comb begin
      if (Stall) begin
         issue = IssueHold;
      end else if (empty || (Flush && !ds_pending_q)) begin
         issue = IssueBubble;
      end else begin
         issue = IssueHead;
      end
      pop = (issue == IssueHead);
   end

   // Pointer and occupancy next state; a flush collapses the queue to at most the delay slot
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (Flush) begin
         if (keep_ds && Stall) begin
            // Delay slot is held back by the stall; keep only the head
            wr_ptr_d = rd_ptr_q + 1'b1;
            count_d  = OneCnt;
         end else begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
         end
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         count_d = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
      end
   end

   // Decode register next state; an issued delay slot never re-arms the jump detector
   always_comb begin
      issue_instr_d = issue_instr_q;
      issue_pc_d    = issue_pc_q;
      issue_valid_d = issue_valid_q;
      jump_d        = 1'b0;
      ds_pending_d  = ds_pending_q;
      unique case (issue)
         IssueHead: begin
            issue_instr_d = head_instr;
            issue_pc_d    = head_pc;
            issue_valid_d = 1'b1;
            jump_d        = head_is_jump & ~ds_pending_q;
            ds_pending_d  = head_is_jump & ~ds_pending_q;
         end
         IssueBubble: begin
            issue_instr_d = WIDTH'(NOP);
            issue_pc_d    = '0;
            issue_valid_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Control state with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         issue_instr_q <= '0;
         issue_pc_q    <= '0;
         issue_valid_q <= 1'b0;
         jump_q        <= 1'b0;
         ds_pending_q  <= 1'b0;
      end else begin
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         issue_instr_q <= issue_instr_d;
         issue_pc_q    <= issue_pc_d;
         issue_valid_q <= issue_valid_d;
         jump_q        <= jump_d;
         ds_pending_q  <= ds_pending_d;
      end
   end

   // Entry storage; contents are only meaningful between the pointers, so no reset
   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         instr_mem_q[wr_ptr_q] <= InstrF;
         pc_mem_q[wr_ptr_q]    <= PCPlus4F;
      end
   end

`ifdef FETCH_FLUSH_STATS_EN
   logic [31:0] SquashCount;
   logic [31:0] BubbleCount;
   logic [PtrW:0] discard_n;

   // Entries thrown away this cycle: everything except a surviving delay slot
   always_comb begin
      discard_n = '0;
      if (Flush) begin
         discard_n = count_q - (PtrW + 1)'(keep_ds);
      end
   end

   // Statistics counters
   always_ff @(posedge CLK) begin
      if (RST) begin
         SquashCount <= '0;
         BubbleCount <= '0;
      end else begin
         SquashCount <= SquashCount + 32'(discard_n);
         if (issue == IssueBubble) begin
            BubbleCount <= BubbleCount + 32'd1;
         end
`ifdef DEBUG_PRINT
         if (discard_n != '0) begin
            $display("Squash on Flush");
         end
`endif
      end
   end
`endif

   assign InstrD   = issue_instr_q;
   assign PCPlus4D = issue_pc_q;
   assign ValidD   = issue_valid_q;
   assign Jump     = jump_q;

endmodule
